// File: rtl/core_pkg.sv
// Shared issue-stage types: instruction format codes, issue FSM states and
// the operand-use decoding helpers.
package core_pkg;

    typedef enum logic [2:0] {
        IT_I  = 3'd0,
        IT_U  = 3'd1,
        IT_S  = 3'd2,
        IT_R  = 3'd3,
        IT_SB = 3'd4,
        IT_UJ = 3'd5
    } itype_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } issue_state_e;

    // Codes 6 and 7 decode like I-type, so only U/UJ skip rs1.
    function automatic logic uses_rs1(input logic [2:0] itype);
        case (itype)
            IT_U, IT_UJ: uses_rs1 = 1'b0;
            default:     uses_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [2:0] itype);
        case (itype)
            IT_S, IT_R, IT_SB: uses_rs2 = 1'b1;
            default:           uses_rs2 = 1'b0;
        endcase
    endfunction

    // Stores and branches never write; a write to x0 is discarded.
    function automatic logic writes_rd(input logic [2:0] itype, input logic [4:0] rd);
        case (itype)
            IT_S, IT_SB: writes_rd = 1'b0;
            default:     writes_rd = (rd != 5'd0);
        endcase
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue and issue-to-execute handshake bundle.
// Handshake rule: a transfer happens on a clock edge where valid and ready are
// both high; the producer holds its payload stable while valid && !ready.
interface issue_scoreboard_if;
    import core_pkg::*;

    logic       dec_valid;
    logic       dec_ready;
    logic [2:0] dec_itype;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       iss_valid;
    logic       iss_ready;

    // Decode/execute side of the pipeline.
    modport master (
        output dec_valid, dec_itype, dec_rd, dec_rs1, dec_rs2, iss_ready,
        input  dec_ready, iss_valid
    );

    // Issue controller.
    modport slave (
        input  dec_valid, dec_itype, dec_rd, dec_rs1, dec_rs2, iss_ready,
        output dec_ready, iss_valid
    );

endinterface

// File: rtl/scoreboard_regs.sv
// 32-entry pending-write bit array. A set and a clear of the same register in
// one cycle leaves it busy; x0 can never become busy.
module scoreboard_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en_i,
    input  logic [4:0]  set_idx_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_idx_i,
    output logic [31:0] busy_o,
    output logic [31:0] busy_byp_o
);
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Next busy vector: clear first, then set so the set wins; mask x0.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_idx_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
        busy_d = ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    // Busy bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o     = busy_q;
    // Hazard view: a register retiring this cycle already counts as free.
    assign busy_byp_o = busy_q & ~clr_mask;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage controller: RAW hazard blocking via the busy scoreboard,
// in-flight limiting, redirect flush bubbles and a stall-cycle counter.
module issue_scoreboard
    import core_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    issue_scoreboard_if.slave    dec_if,
    input  logic                 ret_valid,
    input  logic                 ret_we,
    input  logic [4:0]           ret_rd,
    input  logic                 redirect,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [31:0]          busy_o,
    output issue_state_e         state_o,
    output logic                 err_o
);
    localparam logic [3:0] MAX_Q      = 4'(MAX_INFLIGHT);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    issue_state_e     state_q;
    logic [1:0]       flush_cnt_q;
    logic [3:0]       inflight_q;
    logic [3:0]       inflight_d;
    logic [CNT_W-1:0] stall_q;
    logic             err_q;

    logic [31:0] busy_byp;
    logic        hazard;
    logic        full;
    logic        iss_valid;
    logic        fire;
    logic        ret_eff;
    logic        set_en;
    logic        clr_en;
    logic        stall_cyc;

    // Hazard, capacity and handshake decisions for the current cycle.
    always_comb begin
        hazard    = (uses_rs1(dec_if.dec_itype) && busy_byp[dec_if.dec_rs1]) ||
                    (uses_rs2(dec_if.dec_itype) && busy_byp[dec_if.dec_rs2]);
        full      = (inflight_q == MAX_Q) && !ret_valid;
        iss_valid = rst_n && dec_if.dec_valid && (state_q == ST_RUN) &&
                    !hazard && !full && !redirect;
        fire      = iss_valid && dec_if.iss_ready;
        set_en    = fire && writes_rd(dec_if.dec_itype, dec_if.dec_rd);
        clr_en    = ret_valid && ret_we;
        ret_eff   = ret_valid && (inflight_q != 4'd0);
        stall_cyc = (state_q == ST_RUN) && dec_if.dec_valid && (hazard || full) && !redirect;
        inflight_d = inflight_q + {3'b000, fire} - {3'b000, ret_eff};
    end

    // During a flush the decode instruction is consumed and dropped.
    assign dec_if.iss_valid = iss_valid;
    assign dec_if.dec_ready = (state_q == ST_FLUSH) ? 1'b1 : fire;

    scoreboard_regs u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (set_en),
        .set_idx_i  (dec_if.dec_rd),
        .clr_en_i   (clr_en),
        .clr_idx_i  (ret_rd),
        .busy_o     (busy_o),
        .busy_byp_o (busy_byp)
    );

    // Redirect bubble FSM: RUN -> FLUSH for FLUSH_CYCLES cycles, reloaded by a new redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (redirect)                flush_cnt_q <= FLUSH_LOAD;
                    else if (flush_cnt_q == 2'd0) state_q    <= ST_RUN;
                    else                         flush_cnt_q <= flush_cnt_q - 2'd1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // In-flight count; a retire with nothing in flight is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (ret_valid && (inflight_q == 4'd0)) err_q <= 1'b1;
        end
    end

    // Saturating count of cycles lost to hazards or the in-flight limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        stall_q <= '0;
        else if (stall_cyc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
    assign state_o   = state_q;
    assign err_o     = err_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-stage controller between the instruction decode/field-split stage and execute in the pipelined RV32 core.
- Keeps a 32-entry pending-write scoreboard and blocks RAW hazards, including load-use.
- Limits the number of in-flight instructions and handles redirect flush bubbles.
- Issues one instruction per cycle through valid/ready handshakes on both sides.

Parameters:
- MAX_INFLIGHT, 4, max instructions issued but not yet retired (range 1..15).
- FLUSH_CYCLES, 1, bubble cycles held after a redirect (range 1..3).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode stage holds an instruction.
- dec_ready  out  1  issue accepts the decode instruction this cycle.
- dec_itype  in  3  format code: 0 I, 1 U, 2 S, 3 R, 4 SB, 5 UJ.
- dec_rd, dec_rs1, dec_rs2  in  5 each  register fields.
- iss_valid  out  1  instruction presented to execute.
- iss_ready  in  1  execute accepts.
- ret_valid  in  1  one instruction retires this cycle.
- ret_we  in  1  the retiring instruction writes a register.
- ret_rd  in  5  destination of the retiring instruction.
- redirect  in  1  branch/jump mispredict pulse from execute.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.
- busy_o  out  32  scoreboard bits, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - Scoreboard clears to 0.
  - inflight counter = 0, state = RUN, stall_cnt = 0.
  - dec_ready = 0, iss_valid = 0.
- Source and destination use:
  - uses_rs1 for itype in {I, S, R, SB}.
  - uses_rs2 for itype in {S, R, SB}.
  - writes_rd for itype in {I, U, R, UJ} and rd != 0.
  - itype 6 and 7 are treated as I.
  - Register x0 is never busy.
- Hazard:
  - A hazard exists when (uses_rs1 and busy[rs1]) or (uses_rs2 and busy[rs2]).
  - Exception: a busy bit being cleared by a retire in the same cycle does not count (retire-clear bypass).
- Inflight limit: issue is blocked when inflight == MAX_INFLIGHT, unless ret_valid is high in the same cycle.
- Combinational outputs:
  - iss_valid = dec_valid & state==RUN & !hazard & !full & !redirect.
  - dec_ready = iss_valid & iss_ready.
- Fire: fire = iss_valid & iss_ready.
  - On fire with writes_rd, busy[rd] is set next cycle.
  - On retire with ret_we, busy[ret_rd] is cleared.
  - If the same register is cleared and set in one cycle, set wins.
- inflight update:
  - inflight += fire, inflight -= ret_valid; both together leave it unchanged.
  - A retire at inflight == 0 is ignored, and a sticky error bit is set (assertion target).
- stall_cnt increments each cycle in RUN with dec_valid & (hazard | full) & !redirect.
  - Saturates at all-ones.
- FSM states:
  - RUN: on redirect, go to FLUSH and load the bubble counter with FLUSH_CYCLES-1.
  - FLUSH: dec_ready = 1 (the decode instruction is dropped), iss_valid = 0. The counter decrements; at 0 the FSM returns to RUN.
  - A redirect during FLUSH reloads the counter.
- Redirect does not touch the scoreboard or inflight. Already-issued instructions still retire and clear their bits.
- iss_valid may drop without iss_ready only because of redirect. Otherwise, while stalled on iss_ready, the presented instruction is held stable.
- Reset mid-operation discards all pending bits immediately; no retire is expected afterwards.

Decomposition:
- Shared package core_pkg holds:
  - itype_e enum (I=0, U=1, S=2, R=3, SB=4, UJ=5).
  - Helper functions uses_rs1/uses_rs2/writes_rd.
  - The issue FSM state enum.
- One sub-module, scoreboard_regs: the 32-bit busy array with set/clear ports, set-priority rule and the x0 mask.
- The FSM, inflight counter and stall counter live in the top level.

Test Plan:
- Reset then R-type add x5,x1,x2 with iss_ready=1:
  - fires on cycle 1.
  - busy_o[5]=1 on cycle 2.
  - ret_valid/ret_we/ret_rd=5 clears the bit the next cycle.
- Load-use: I-type x5 issued (not retired), then R-type rs1=5:
  - iss_valid=0 and stall_cnt increments each cycle.
  - A retire of rd=5 on cycle k issues the dependent instruction on the same cycle k (bypass).
- Store (S) with rs2=7 while busy[7]=1 stalls.
- U-type writing x7 does not stall on busy[rs1] garbage fields.
- rd=x0: an I-type to x0 leaves busy_o==0, and a following consumer of x0 issues without stall.
- Inflight limit, MAX_INFLIGHT=4:
  - Issue 4 independent instructions with no retire; the 5th has iss_valid=0.
  - A simultaneous retire lets it fire the same cycle.
- Redirect with FLUSH_CYCLES=2 while a valid instruction is waiting:
  - iss_valid=0 for 2 cycles and dec_ready=1 drops the decode instructions.
  - busy bits of issued instructions are retained.
  - An async rst_n pulse mid-FLUSH returns the FSM to RUN with busy_o=0.
